// File: rtl/refill_pkg.sv
// Shared sizes, FSM encoding and queue-entry layout for the miss refill controller.
// Pure declarations: no logic or latency; backpressure lives in the users of these types.
package refill_pkg;

    localparam int LINE_SIZE   = 32;
    localparam int BEAT_BYTES  = 4;
    localparam int BEATS       = LINE_SIZE / BEAT_BYTES;
    localparam int OFFSET_BITS = $clog2(LINE_SIZE);
    localparam int BEAT_IDX_W  = $clog2(BEATS);
    localparam int BEAT_W      = BEAT_BYTES * 8;
    localparam int LINE_W      = LINE_SIZE * 8;
    localparam int ADDR_W      = 31;
    localparam int WAY_W       = 2;
    localparam int DEF_QDEPTH  = 2;
    localparam int CNT_W       = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        COLLECT = 2'd2,
        FILL    = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] line_addr;
        logic [WAY_W-1:0]  way;
    } q_entry_t;

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'((1 << OFFSET_BITS) - 1);
    endfunction

endpackage

// File: rtl/miss_queue_fifo.sv
// Small FIFO of pending misses with a parallel line-address match across valid entries.
// Head visible combinationally; push ignored when full, pop ignored when empty.
module miss_queue_fifo
    import refill_pkg::*;
#(
    parameter int DEPTH = DEF_QDEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  q_entry_t          push_entry,
    input  logic              pop,
    output q_entry_t          head,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] match_addr,
    output logic              match
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    q_entry_t           entries [DEPTH];
    logic [DEPTH-1:0]   occupied;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entries[rd_ptr];

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && entries[i].line_addr == match_addr) begin
                match = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            occupied <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr           <= next_ptr(rd_ptr);
                occupied[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr           <= next_ptr(wr_ptr);
                occupied[wr_ptr] <= 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: occupied[] gates every use of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/miss_refill_ctrl.sv
// Queues cache misses, issues one line burst at a time and returns the assembled line as a fill.
// Accept-to-request 2 cycles, last beat to fill 1 cycle; miss_ready_41 drops when the queue is full.
module miss_refill_ctrl
    import refill_pkg::*;
#(
    parameter int QDEPTH = DEF_QDEPTH
) (
    input  logic              clk_41,
    input  logic              rst_41,
    input  logic              miss_valid_41,
    output logic              miss_ready_41,
    input  logic [ADDR_W-1:0] miss_addr_41,
    input  logic [WAY_W-1:0]  miss_way_41,
    output logic              mem_req_valid_41,
    input  logic              mem_req_ready_41,
    output logic [ADDR_W-1:0] mem_req_addr_41,
    input  logic              mem_rdata_valid_41,
    input  logic [BEAT_W-1:0] mem_rdata_41,
    output logic              fill_valid_41,
    output logic [ADDR_W-1:0] fill_addr_41,
    output logic [WAY_W-1:0]  fill_way_41,
    output logic [LINE_W-1:0] fill_data_41,
    output logic              busy_41,
    output logic [CNT_W-1:0]  refills_41,
    output logic [CNT_W-1:0]  merged_41
);
    state_t                state;
    state_t                state_nxt;
    q_entry_t              inflight;
    q_entry_t              head;
    q_entry_t              new_entry;
    logic [BEAT_IDX_W-1:0] beat_cnt;
    logic                  q_full;
    logic                  q_empty;
    logic                  q_match;
    logic                  q_push;
    logic                  q_pop;
    logic                  accept;
    logic                  inflight_hit;
    logic                  merge_hit;
    logic                  beat_take;
    logic                  last_beat;

    assign new_entry.line_addr = line_of(miss_addr_41);
    assign new_entry.way       = miss_way_41;

    assign miss_ready_41 = !q_full;
    assign accept        = miss_valid_41 && miss_ready_41;
    // The in-flight line counts as pending until the fill cycle has ended.
    assign inflight_hit  = (state != IDLE) && (inflight.line_addr == new_entry.line_addr);
    assign merge_hit     = inflight_hit || q_match;
    assign q_push        = accept && !merge_hit;
    assign beat_take     = (state == COLLECT) && mem_rdata_valid_41;
    assign last_beat     = beat_take && (beat_cnt == BEAT_IDX_W'(BEATS - 1));

    miss_queue_fifo #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk        (clk_41),
        .rst        (rst_41),
        .push       (q_push),
        .push_entry (new_entry),
        .pop        (q_pop),
        .head       (head),
        .full       (q_full),
        .empty      (q_empty),
        .match_addr (new_entry.line_addr),
        .match      (q_match)
    );

    always_ff @(posedge clk_41) begin
        if (!rst_41) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!q_empty) state_nxt = REQ;
            REQ:     if (mem_req_ready_41) state_nxt = COLLECT;
            COLLECT: if (last_beat) state_nxt = FILL;
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_pop            = (state == IDLE) && !q_empty;
        mem_req_valid_41 = (state == REQ);
        fill_valid_41    = (state == FILL);
        busy_41          = (state != IDLE) || !q_empty;
    end

    assign mem_req_addr_41 = inflight.line_addr;

    always_ff @(posedge clk_41) begin
        if (!rst_41) begin
            inflight     <= '0;
            beat_cnt     <= '0;
            fill_addr_41 <= '0;
            fill_way_41  <= '0;
            fill_data_41 <= '0;
            refills_41   <= '0;
            merged_41    <= '0;
        end else begin
            if (q_pop) begin
                inflight <= head;
            end
            if (state == REQ && mem_req_ready_41) begin
                beat_cnt <= '0;
            end else if (beat_take) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (beat_take) begin
                fill_data_41[beat_cnt*BEAT_W +: BEAT_W] <= mem_rdata_41;
            end
            if (last_beat) begin
                fill_addr_41 <= inflight.line_addr;
                fill_way_41  <= inflight.way;
            end
            if (state == FILL) begin
                refills_41 <= refills_41 + 1'b1;
            end
            if (accept && merge_hit) begin
                merged_41 <= merged_41 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_miss_refill_ctrl.sv
// Bench for miss_refill_ctrl: directed scenarios plus random traffic, scored against a
// transaction-level model of pending lines, one outstanding burst and beat assembly.
module tb_miss_refill_ctrl;

    localparam int QD = 2;
    localparam int NB = 8;

    typedef struct {
        logic [30:0] line;
        logic [1:0]  way;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         miss_valid;
    logic         miss_ready;
    logic [30:0]  miss_addr;
    logic [1:0]   miss_way;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [30:0]  mem_req_addr;
    logic         mem_rdata_valid;
    logic [31:0]  mem_rdata;
    logic         fill_valid;
    logic [30:0]  fill_addr;
    logic [1:0]   fill_way;
    logic [255:0] fill_data;
    logic         busy;
    logic [30:0]  refills;
    logic [30:0]  merged;

    always #5 clk = ~clk;

    miss_refill_ctrl dut (
        .clk_41             (clk),
        .rst_41             (rst),
        .miss_valid_41      (miss_valid),
        .miss_ready_41      (miss_ready),
        .miss_addr_41       (miss_addr),
        .miss_way_41        (miss_way),
        .mem_req_valid_41   (mem_req_valid),
        .mem_req_ready_41   (mem_req_ready),
        .mem_req_addr_41    (mem_req_addr),
        .mem_rdata_valid_41 (mem_rdata_valid),
        .mem_rdata_41       (mem_rdata),
        .fill_valid_41      (fill_valid),
        .fill_addr_41       (fill_addr),
        .fill_way_41        (fill_way),
        .fill_data_41       (fill_data),
        .busy_41            (busy),
        .refills_41         (refills),
        .merged_41          (merged)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    ent_t         m_q[$];
    ent_t         m_ent;
    bit           m_if;
    bit           m_req_done;
    bit           m_fill_now;
    bit           started = 1'b0;
    int           m_beats;
    int           req_hs;
    logic [255:0] m_data;
    logic [30:0]  m_faddr;
    logic [1:0]   m_fway;
    logic [30:0]  m_refills;
    logic [30:0]  m_merged;

    // Monitor: compare DUT against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        bit          if_s;
        bit          rd_s;
        bit          pop_now;
        bit          hit;
        logic [30:0] ln;
        if (started) begin
            chk("miss_ready", miss_ready, m_q.size() < QD);
            chk("req_valid", mem_req_valid, m_if && !m_req_done);
            if (m_if && !m_req_done) chk("req_addr", mem_req_addr, m_ent.line);
            chk("fill_valid", fill_valid, m_fill_now);
            chk("fill_addr", fill_addr, m_faddr);
            chk("fill_way", fill_way, m_fway);
            chk("fill_data", fill_data, m_data);
            chk("refills", refills, m_refills);
            chk("merged", merged, m_merged);
            chk("busy", busy, m_if || (m_q.size() != 0));
        end
        if (!rst) begin
            m_q.delete();
            m_if       = 1'b0;
            m_req_done = 1'b0;
            m_fill_now = 1'b0;
            m_beats    = 0;
            m_data     = '0;
            m_faddr    = '0;
            m_fway     = '0;
            m_refills  = '0;
            m_merged   = '0;
            started    = 1'b1;
        end else if (started) begin
            if_s    = m_if;
            rd_s    = m_req_done;
            pop_now = !if_s && (m_q.size() > 0);
            if (mem_req_valid && mem_req_ready) req_hs++;
            if (m_fill_now) begin
                m_fill_now = 1'b0;
                m_if       = 1'b0;
                m_refills++;
            end
            if (miss_valid && m_q.size() < QD) begin
                ln  = miss_addr & ~31'h1f;
                hit = if_s && (m_ent.line == ln);
                foreach (m_q[i]) if (m_q[i].line == ln) hit = 1'b1;
                if (hit) m_merged++;
                else m_q.push_back('{ln, miss_way});
            end
            if (if_s && !rd_s && mem_req_ready) begin
                m_req_done = 1'b1;
                m_beats    = 0;
            end
            if (if_s && rd_s && m_beats < NB && mem_rdata_valid) begin
                m_data[m_beats*32 +: 32] = mem_rdata;
                m_beats++;
                if (m_beats == NB) begin
                    m_fill_now = 1'b1;
                    m_faddr    = m_ent.line;
                    m_fway     = m_ent.way;
                end
            end
            if (pop_now) begin
                m_ent      = m_q.pop_front();
                m_if       = 1'b1;
                m_req_done = 1'b0;
                m_beats    = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_miss(input logic [30:0] a, input logic [1:0] w);
        miss_valid = 1'b1;
        miss_addr  = a;
        miss_way   = w;
        tick();
        miss_valid = 1'b0;
    endtask

    task automatic wait_req();
        int w = 0;
        while (!mem_req_valid && w < 50) begin
            tick();
            w++;
        end
        chk("req_wait_bound", mem_req_valid, 1'b1);
    endtask

    task automatic serve_line(input int gap);
        wait_req();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < NB; b++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
            tick();
            mem_rdata_valid = 1'b0;
            repeat (gap) tick();
        end
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          base_hs;
        logic [30:0] base_m;
        rst             = 1'b0;
        miss_valid      = 1'b0;
        miss_addr       = '0;
        miss_way        = '0;
        mem_req_ready   = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata       = '0;
        req_hs          = 0;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Single miss with exact cycle timing
        mem_req_ready = 1'b1;
        send_miss(31'h1234, 2'd2);
        tick();
        chk("t1_req_valid_c2", mem_req_valid, 1'b1);
        chk("t1_req_addr_c2", mem_req_addr, 31'h1220);
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < NB; i++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = 32'(32'h11111111 * (i + 1));
            tick();
        end
        mem_rdata_valid = 1'b0;
        chk("t1_fill_valid_c11", fill_valid, 1'b1);
        chk("t1_fill_way", fill_way, 2'd2);
        chk("t1_data_lo", fill_data[31:0], 32'h11111111);
        chk("t1_data_hi", fill_data[255:224], 32'h88888888);
        tick();
        chk("t1_refills", refills, 31'd1);
        tick();

        // Merge against the in-flight line
        base_hs = req_hs;
        base_m  = merged;
        send_miss(31'h1220, 2'd1);
        repeat (2) tick();
        send_miss(31'h123C, 2'd3);
        chk("t2_merged", merged, base_m + 31'd1);
        serve_line(0);
        repeat (3) tick();
        chk("t2_one_request", req_hs - base_hs, 1);

        // Full queue behind a stalled request
        send_miss(31'h40, 2'd0);
        send_miss(31'h80, 2'd1);
        send_miss(31'hC0, 2'd2);
        miss_valid = 1'b1;
        miss_addr  = 31'h100;
        miss_way   = 2'd3;
        repeat (4) tick();
        chk("t3_ready_low", miss_ready, 1'b0);
        miss_valid = 1'b0;
        serve_line(0);
        chk("t3_ready_after_pop", miss_ready, 1'b1);
        serve_line(0);
        serve_line(0);

        // Gapped beats
        send_miss(31'h5A4, 2'd1);
        serve_line(1);

        // Reset in the middle of a burst
        send_miss(31'h2000, 2'd1);
        wait_req();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
            tick();
        end
        mem_rdata_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t5_req_valid", mem_req_valid, 1'b0);
        chk("t5_fill_valid", fill_valid, 1'b0);
        chk("t5_busy", busy, 1'b0);
        chk("t5_fill_data", fill_data, 256'd0);
        chk("t5_merged", merged, 31'd0);
        for (int b = 0; b < 5; b++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
            tick();
        end
        mem_rdata_valid = 1'b0;
        tick();
        chk("t5_refills_zero", refills, 31'd0);

        // Stray beats while idle
        for (int b = 0; b < 4; b++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
            tick();
        end
        mem_rdata_valid = 1'b0;
        tick();
        chk("t6_fill_data", fill_data, 256'd0);

        // Random traffic over a few lines so merges occur often
        for (int c = 0; c < 600; c++) begin
            miss_valid      = ($urandom_range(0, 2) == 0);
            miss_addr       = 31'(32'h1000 + $urandom_range(0, 5) * 32 + $urandom_range(0, 31));
            miss_way        = 2'($urandom_range(0, 3));
            mem_req_ready   = $urandom_range(0, 1) == 1;
            mem_rdata_valid = ($urandom_range(0, 2) != 0);
            mem_rdata       = $urandom;
            tick();
        end

        miss_valid    = 1'b0;
        mem_req_ready = 1'b1;
        for (int c = 0; c < 300 && busy; c++) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = $urandom;
            tick();
        end
        mem_rdata_valid = 1'b0;
        mem_req_ready   = 1'b0;
        tick();
        chk("drain_idle", busy, 1'b0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/miss_refill_ctrl.md
Name: miss_refill_ctrl

Overview:
- Downstream of the set-associative cache lookup stage. Accepts that stage's miss events: miss address plus victim way.
- Queues them, issues one line-aligned burst read per miss to next-level memory, and assembles the returned beats into a full line.
- Presents the full line back to the cache array as a one-cycle fill.
- Merges duplicate misses to a line already pending or in flight, and counts completed refills and merges.

Parameters:
- LINE_SIZE, 32, cache line size in bytes.
- BEAT_BYTES, 4, bytes returned per memory beat; BEATS = LINE_SIZE/BEAT_BYTES (8).
- ADDR_W, 31, address width.
- WAY_W, 2, victim way index width (log2 of associativity 4).
- QDEPTH, 2, miss queue depth.

Ports:
- clk_41  in  1  clock; all logic on rising edge.
- rst_41  in  1  synchronous, active-low reset.
- miss_valid_41  in  1  miss event valid.
- miss_ready_41  out  1  queue can accept a miss.
- miss_addr_41  in  ADDR_W  byte address that missed.
- miss_way_41  in  WAY_W  victim way chosen by the lookup stage.
- mem_req_valid_41  out  1  burst read request valid.
- mem_req_ready_41  in  1  memory accepts request.
- mem_req_addr_41  out  ADDR_W  line-aligned request address.
- mem_rdata_valid_41  in  1  read beat valid; no backpressure.
- mem_rdata_41  in  BEAT_BYTES*8  read beat data.
- fill_valid_41  out  1  one-cycle line fill strobe.
- fill_addr_41  out  ADDR_W  line-aligned fill address.
- fill_way_41  out  WAY_W  way to write.
- fill_data_41  out  LINE_SIZE*8  assembled line.
- busy_41  out  1  FSM not IDLE or queue non-empty.
- refills_41  out  31  completed fills, wraps modulo 2^31.
- merged_41  out  31  merged misses, wraps modulo 2^31.

Behaviour:
- Reset, when rst_41 is low at a clock edge:
  - FSM goes to IDLE; queue emptied; beat counter cleared.
  - All registered outputs go to 0: mem_req_valid_41, fill_valid_41, fill_*, refills_41, merged_41.
  - Applies mid-burst as well; the in-flight request is abandoned.
  - Beats arriving after reset, while in IDLE, are ignored.
- Line address = miss_addr_41 with the low log2(LINE_SIZE) bits forced to 0.
- miss_ready_41 = queue not full; combinational from the queue count only.
- Accept = miss_valid_41 & miss_ready_41. On accept:
  - If the line address equals the in-flight line (FSM not IDLE) or any valid queue entry: the miss is not enqueued and merged_41 increments.
  - Otherwise {line address, way} is enqueued.
- Same-cycle pop and push on a non-full queue are both honoured. The merge compare sees the pre-pop contents plus the in-flight register.
- FSM states:
  - IDLE: if the queue is non-empty, pop the head into in-flight registers and go to REQ.
  - REQ: mem_req_valid_41 = 1 and mem_req_addr_41 = in-flight line. On mem_req_ready_41, go to COLLECT with beat counter 0.
  - COLLECT: each mem_rdata_valid_41 writes mem_rdata_41 into fill_data_41 bits [beat*BEAT_BYTES*8 +: BEAT_BYTES*8], then the beat counter increments. On beat BEATS-1, go to FILL. Gaps between beats are allowed.
  - FILL: fill_valid_41 = 1 for exactly one cycle, with fill_addr_41/fill_way_41 = in-flight values. refills_41 increments, then go to IDLE.
- mem_rdata_valid_41 outside COLLECT is ignored.
- fill_data_41, fill_addr_41 and fill_way_41 hold their values after FILL until the next beat or fill.
- Minimum latency, with the accept in cycle 0:
  - mem_req_valid_41 first high in cycle 2.
  - With ready in cycle 2 and back-to-back beats in cycles 3–10, fill_valid_41 is high in cycle 11.
- Only one burst is outstanding at a time.

Decomposition:
- Shared package refill_pkg holds:
  - LINE_SIZE, BEAT_BYTES, BEATS, OFFSET_BITS = log2(LINE_SIZE), BEAT_IDX_W.
  - State encoding IDLE/REQ/COLLECT/FILL.
  - The queue-entry struct {line_addr, way}.
- One sub-module: miss_queue_fifo, a QDEPTH-entry FIFO with push/pop, full/empty, and a parallel line-address match output used for merging.

Test Plan:
- Single miss: addr 0x0000_1234 with way 2 accepted in cycle 0; ready tied high; beats 0x11111111..0x88888888 in cycles 3–10. Required: mem_req_addr_41 = 0x0000_1220 in cycle 2; fill_valid_41 in cycle 11 with fill_way_41 = 2; fill_data_41[31:0] = 0x11111111 and [255:224] = 0x88888888; refills_41 = 1.
- Merge: miss 0x1220 in flight, then miss 0x123C accepted. Required: queue unchanged, merged_41 = 1, exactly one memory request.
- Full queue: burst stalled (mem_req_ready_41 = 0) with misses to 0x40, 0x80, 0xC0. Required: the first goes in flight, the next two fill the queue, and miss_ready_41 = 0 until the stalled request is accepted and the queue pops.
- Gapped beats: beats only on alternate cycles. Required: fill_valid_41 exactly one cycle after the 8th beat, with data correct and in order.
- Reset mid-COLLECT: rst_41 low after 3 beats. Required: next cycle all outputs 0 and FSM IDLE; the 5 remaining beats produce no fill; refills_41 stays 0.
- Stray beats: mem_rdata_valid_41 pulsed while IDLE. Required: fill_data_41 unchanged and no fill.
